spi_flash_responder: RTL and testbench

- Synthesizable SPI flash target (SPI mode 0). It is the responder end of the link driven by MappedSPIFlash (CLK/CS_N/MOSI/MISO).
- Decodes READ (0x03) and FAST READ (0x0B) with a 24-bit address, then streams bytes MSB-first from a byte-wide backing memory port.
- Lets the flash-mapped FemtoRV path run on FPGA or in simulation without a behavioural flash model.
- All SPI inputs are oversampled in the single system clock domain.

---
 rtl/spi_flash_responder_if.sv | 36 +++
 rtl/spi_flash_responder.sv | 192 +++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// SPI link and byte-wide backing-memory port of the SPI flash responder.
// The slave modport is the responder's view; master is the initiator/memory side.
interface spi_flash_responder_if #(
    parameter int MEM_AW = 16
);
    logic              CLK;
    logic              CS_N;
    logic              MOSI;
    logic              MISO;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              active;

    modport slave (
        input  CLK,
        input  CS_N,
        input  MOSI,
        input  mem_rdata,
        output MISO,
        output mem_addr,
        output mem_rd,
        output active
    );

    modport master (
        output CLK,
        output CS_N,
        output MOSI,
        output mem_rdata,
        input  MISO,
        input  mem_addr,
        input  mem_rd,
        input  active
    );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target answering READ (0x03) and FAST READ (0x0B) from a
// byte-wide memory; all SPI pins are oversampled in the clk domain.
module spi_flash_responder #(
    parameter int MEM_AW       = 16,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_flash_responder_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

    state_t            r_state;
    logic              r_sck_s1, r_sck_s2, r_sck_d;
    logic              r_cs_s1, r_cs_s2;
    logic              r_mosi_s1, r_mosi_s2;
    logic              r_need_high;
    logic [6:0]        r_cmd;
    logic [23:0]       r_addr;
    logic [7:0]        r_cnt;
    logic              r_fast;
    logic [7:0]        r_tx;
    logic [7:0]        r_prefetch;
    logic              r_cap;
    logic              r_miso;
    logic              r_mem_rd;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_active;

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_cs_high;
    logic [7:0]        w_cmd_next;
    logic [23:0]       w_addr_next;
    logic [23:0]       w_addr_inc;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_d;
    assign w_cs_high   = r_cs_s2;
    assign w_cmd_next  = {r_cmd, r_mosi_s2};
    assign w_addr_next = {r_addr[22:0], r_mosi_s2};
    assign w_addr_inc  = r_addr + 24'd1;

    assign bus.MISO     = r_miso;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_addr = r_mem_addr;
    assign bus.active   = r_active;

    // Synchronizers, command/address decode, prefetch and MISO shifter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_sck_s1    <= 1'b0;
            r_sck_s2    <= 1'b0;
            r_sck_d     <= 1'b0;
            r_cs_s1     <= 1'b0;
            r_cs_s2     <= 1'b0;
            r_mosi_s1   <= 1'b0;
            r_mosi_s2   <= 1'b0;
            r_need_high <= 1'b1;
            r_cmd       <= 7'd0;
            r_addr      <= 24'd0;
            r_cnt       <= 8'd0;
            r_fast      <= 1'b0;
            r_tx        <= 8'd0;
            r_prefetch  <= 8'd0;
            r_cap       <= 1'b0;
            r_miso      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
            r_active    <= 1'b0;
        end else begin
            r_sck_s1  <= bus.CLK;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_cs_s1   <= bus.CS_N;
            r_cs_s2   <= r_cs_s1;
            r_mosi_s1 <= bus.MOSI;
            r_mosi_s2 <= r_mosi_s1;

            // Memory returns data one clk after the strobe; grab it the clk after that.
            r_mem_rd <= 1'b0;
            r_cap    <= r_mem_rd;
            if (r_cap) begin
                r_prefetch <= bus.mem_rdata;
            end

            // Deselect beats any SCK edge seen in the same cycle.
            if (w_cs_high && (r_state != ST_IDLE)) begin
                r_state  <= ST_IDLE;
                r_cnt    <= 8'd0;
                r_cmd    <= 7'd0;
                r_addr   <= 24'd0;
                r_fast   <= 1'b0;
                r_tx     <= 8'd0;
                r_miso   <= 1'b0;
                r_active <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_miso <= 1'b0;
                        if (w_cs_high) begin
                            r_need_high <= 1'b0;
                        end else if (!r_need_high) begin
                            r_state  <= ST_CMD;
                            r_cnt    <= 8'd0;
                            r_active <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        if (w_sck_rise) begin
                            r_cmd <= w_cmd_next[6:0];
                            if (r_cnt == 8'd7) begin
                                r_cnt <= 8'd0;
                                if (w_cmd_next == 8'h03) begin
                                    r_state <= ST_ADDR;
                                    r_fast  <= 1'b0;
                                end else if (w_cmd_next == 8'h0B) begin
                                    r_state <= ST_ADDR;
                                    r_fast  <= 1'b1;
                                end else begin
                                    r_state <= ST_IGNORE;
                                end
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (w_sck_rise) begin
                            r_addr <= w_addr_next;
                            if (r_cnt == 8'd23) begin
                                r_cnt      <= 8'd0;
                                r_mem_rd   <= 1'b1;
                                r_mem_addr <= w_addr_next[MEM_AW-1:0];
                                r_state    <= (r_fast && (DUMMY_CYCLES != 0)) ? ST_DUMMY : ST_DATA;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                    ST_DUMMY: begin
                        r_miso <= 1'b0;
                        if (w_sck_rise) begin
                            if (r_cnt == DUMMY_LAST) begin
                                r_cnt   <= 8'd0;
                                r_state <= ST_DATA;
                            end else begin
                                r_cnt <= r_cnt + 8'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (w_sck_fall) begin
                            r_cnt <= r_cnt + 8'd1;
                            // Byte boundary: present the prefetched byte and fetch the next one.
                            if (r_cnt[2:0] == 3'd0) begin
                                r_miso     <= r_prefetch[7];
                                r_tx       <= {r_prefetch[6:0], 1'b0};
                                r_addr     <= w_addr_inc;
                                r_mem_rd   <= 1'b1;
                                r_mem_addr <= w_addr_inc[MEM_AW-1:0];
                            end else begin
                                r_miso <= r_tx[7];
                                r_tx   <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end
                    ST_IGNORE: begin
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_miso   <= 1'b0;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: bit-banged SPI master, byte memory model and
// a reference computed straight from memory contents and address arithmetic.
module tb_spi_flash_responder;

    localparam int MEM_AW = 16;
    localparam int DUMMY  = 8;
    localparam int HALF   = 5;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  dummy_rx;
    int          b2b = 0;
    bit          prev_rd = 1'b0;

    spi_flash_responder_if #(.MEM_AW(MEM_AW)) bus ();

    spi_flash_responder #(.MEM_AW(MEM_AW), .DUMMY_CYCLES(DUMMY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: data valid one clk after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
        else                     bus.mem_rdata <= 8'($urandom);
    end

    // Read-strobe monitor.
    always @(negedge clk) begin
        if (bus.mem_rd === 1'b1) begin
            rd_q.push_back(bus.mem_addr);
            if (prev_rd) b2b++;
        end
        prev_rd = (bus.mem_rd === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        bus.CS_N = 1'b0;
        tick(4);
    endtask

    // Mode-0 shift; on the last bit CS_N rises together with the final SCK fall.
    task automatic spi_bits(input logic [31:0] tx, input int nbits, input bit last,
                            output logic [31:0] rx);
        rx = 32'd0;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.MOSI = tx[i];
            tick(HALF);
            bus.CLK = 1'b1;
            rx[i] = bus.MISO;
            tick(HALF);
            bus.CLK = 1'b0;
            if (last && i == 0) bus.CS_N = 1'b1;
        end
    endtask

    task automatic spi_read(input logic [7:0] cmd, input logic [23:0] addr, input int n);
        logic [31:0] rx;
        rx_q.delete();
        cs_low();
        spi_bits({24'd0, cmd}, 8, 1'b0, rx);
        spi_bits({8'd0, addr}, 24, 1'b0, rx);
        if (cmd == 8'h0B) begin
            spi_bits(32'd0, DUMMY, 1'b0, rx);
            dummy_rx = rx[7:0];
        end
        for (int k = 0; k < n; k++) begin
            spi_bits(32'd0, 8, (k == n - 1), rx);
            rx_q.push_back(rx[7:0]);
        end
        tick(8);
    endtask

    task automatic check_bytes(input string name, input logic [7:0] exp [4], input int n);
        for (int k = 0; k < n; k++) begin
            checks++;
            if (k >= rx_q.size() || rx_q[k] !== exp[k]) begin
                errors++;
                $display("FAIL %s byte%0d: got %h expected %h", name, k,
                         (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.CS_N = 1'b1;
        bus.CLK = 1'b0;
        bus.MOSI = 1'b0;
        tick(3);
        checks++; if (bus.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", bus.MISO); end
        checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", bus.mem_rd); end
        checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", bus.active); end
        checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
        reset = 1'b1;
        tick(6);
    endtask

    task automatic test_read();
        logic [7:0] exp [4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        rd_q.delete();
        spi_read(8'h03, 24'h000010, 4);
        check_bytes("read", exp, 4);
        checks++;
        if (rd_q.size() < 4 || rd_q.size() > 5) begin
            errors++; $display("FAIL read_rd_count: got %0d expected 4 or 5", rd_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= rd_q.size() || rd_q[k] !== 16'(16'h0010 + k)) begin
                errors++; $display("FAIL read_rd_addr%0d: got %h expected %h", k,
                                   (k < rd_q.size()) ? rd_q[k] : 16'hxxxx, 16'(16'h0010 + k));
            end
        end
    endtask

    task automatic test_fast();
        logic [7:0] exp [4] = '{8'hA5, 8'hA4, 8'h00, 8'h00};
        spi_read(8'h0B, 24'h000000, 2);
        checks++; if (dummy_rx !== 8'h00) begin errors++; $display("FAIL fast_dummy_miso: got %h expected 00", dummy_rx); end
        check_bytes("fast", exp, 2);
    endtask

    task automatic test_ignore();
        logic [31:0] rx;
        rd_q.delete();
        cs_low();
        spi_bits(32'h9F, 8, 1'b0, rx);
        spi_bits(32'hFFFF, 16, 1'b0, rx);
        tick(3);
        checks++; if (rx[15:0] !== 16'h0000) begin errors++; $display("FAIL ignore_miso: got %h expected 0000", rx[15:0]); end
        checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL ignore_active: got %b expected 1", bus.active); end
        bus.CS_N = 1'b1;
        tick(8);
        checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL ignore_active_off: got %b expected 0", bus.active); end
        checks++; if (rd_q.size() != 0) begin errors++; $display("FAIL ignore_rd_count: got %0d expected 0", rd_q.size()); end
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        logic [7:0] exp [4] = '{8'hA1, 8'hA0, 8'h00, 8'h00};
        rd_q.delete();
        cs_low();
        spi_bits(32'h03, 8, 1'b0, rx);
        spi_bits(32'hF, 4, 1'b1, rx);
        tick(8);
        spi_read(8'h03, 24'h000004, 2);
        check_bytes("abort", exp, 2);
        checks++;
        if (rd_q.size() < 1 || rd_q[0] !== 16'h0004) begin
            errors++; $display("FAIL abort_first_rd: got %h expected 0004", (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [4] = '{8'h5A, 8'hA5, 8'h00, 8'h00};
        rd_q.delete();
        spi_read(8'h03, 24'hFFFFFF, 2);
        check_bytes("wrap", exp, 2);
        checks++;
        if (rd_q.size() < 2 || rd_q[0] !== 16'hFFFF || rd_q[1] !== 16'h0000) begin
            errors++; $display("FAIL wrap_rd_addr: got %0d strobes first %h expected FFFF then 0000",
                               rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rx;
        logic [7:0] exp [4] = '{8'h95, 8'h00, 8'h00, 8'h00};
        cs_low();
        spi_bits(32'h03, 8, 1'b0, rx);
        spi_bits(32'h000020, 24, 1'b0, rx);
        spi_bits(32'd0, 8, 1'b0, rx);
        checks++; if (rx[7:0] !== 8'h85) begin errors++; $display("FAIL rmid_pre_byte: got %h expected 85", rx[7:0]); end
        spi_bits(32'd0, 3, 1'b0, rx);
        reset = 1'b0;
        tick(1);
        checks++;
        if (bus.MISO !== 1'b0 || bus.mem_rd !== 1'b0 || bus.active !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs: got miso=%b rd=%b active=%b expected all 0",
                               bus.MISO, bus.mem_rd, bus.active);
        end
        tick(1);
        reset = 1'b1;
        tick(4);
        rd_q.delete();
        spi_bits(32'h03, 8, 1'b0, rx);
        spi_bits(32'd0, 24, 1'b0, rx);
        spi_bits(32'd0, 16, 1'b0, rx);
        checks++; if (rx[15:0] !== 16'h0000) begin errors++; $display("FAIL rmid_no_resp_miso: got %h expected 0000", rx[15:0]); end
        checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL rmid_no_resp_active: got %b expected 0", bus.active); end
        checks++; if (rd_q.size() != 0) begin errors++; $display("FAIL rmid_no_resp_rd: got %0d expected 0", rd_q.size()); end
        bus.CS_N = 1'b1;
        tick(8);
        spi_read(8'h03, 24'h000030, 1);
        check_bytes("rmid_after", exp, 1);
    endtask

    task automatic test_words();
        logic [31:0] rcv, rdata, exp;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        b2b = 0;
        for (int i = 0; i < 32; i++) begin
            spi_read(8'h03, 24'(i * 4), 4);
            rcv   = {rx_q[0], rx_q[1], rx_q[2], rx_q[3]};
            rdata = {rcv[7:0], rcv[15:8], rcv[23:16], rcv[31:24]};
            exp   = {mem[4*i+3], mem[4*i+2], mem[4*i+1], mem[4*i]};
            checks++;
            if (rdata !== exp) begin
                errors++; $display("FAIL word%0d: got %h expected %h", i, rdata, exp);
            end
        end
        checks++; if (b2b != 0) begin errors++; $display("FAIL b2b_mem_rd: got %0d expected 0", b2b); end
    endtask

    task automatic test_random();
        logic [23:0] addr, a;
        logic [7:0]  cmd;
        int          n;
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 3) == 0) addr = 24'hFFFFFF - 24'($urandom_range(0, 2));
            else                           addr = 24'($urandom);
            for (int k = 0; k < 4; k++) begin
                a = addr + 24'(k);
                mem[a[15:0]] = 8'($urandom);
            end
            cmd = ($urandom_range(0, 1) == 1) ? 8'h0B : 8'h03;
            n   = $urandom_range(1, 4);
            rd_q.delete();
            spi_read(cmd, addr, n);
            for (int k = 0; k < n; k++) begin
                a = addr + 24'(k);
                checks++;
                if (k >= rx_q.size() || rx_q[k] !== mem[a[15:0]]) begin
                    errors++; $display("FAIL rand%0d byte%0d: addr %h got %h expected %h", t, k, a,
                                       (k < rx_q.size()) ? rx_q[k] : 8'hxx, mem[a[15:0]]);
                end
            end
            checks++;
            if (rd_q.size() < 1 || rd_q[0] !== addr[15:0]) begin
                errors++; $display("FAIL rand%0d first_rd: got %h expected %h", t,
                                   (rd_q.size() > 0) ? rd_q[0] : 16'hxxxx, addr[15:0]);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'hA5;
        test_reset();
        test_read();
        test_fast();
        test_ignore();
        test_abort();
        test_wrap();
        test_reset_mid();
        test_words();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
